// File: rtl/drop_timer.sv
// ---------------------------------------------------------------------------
// drop_timer
//   Latches an 8-bit baggage height on a start strobe and computes the drop
//   time limit t_lim = sqrt(height/4) in unsigned Q4.4 by a restoring
//   bit-pair integer square root of {height, 6'b0}, one result bit per cycle.
//   Once the limit is known, raises a sticky drop command when drop is
//   enabled and the elapsed time has reached the limit.
//
// Ports
//   clk             system clock, all state on rising edge
//   rst             synchronous reset, active-high
//   height[7:0]     unsigned height, sampled on the start edge
//   start           single-cycle strobe, accepted in IDLE and DONE only
//   t_act[7:0]      elapsed time, unsigned Q4.4
//   drop_en         drop permission
//   t_lim[7:0]      computed limit, Q4.4, updated only on the done edge
//   busy            high while the root is being computed
//   done            one-cycle pulse when t_lim is updated
//   drop_activated  sticky drop command, cleared by start or reset
// ---------------------------------------------------------------------------
module drop_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] height,
    input  logic       start,
    input  logic [7:0] t_act,
    input  logic       drop_en,
    output logic [7:0] t_lim,
    output logic       busy,
    output logic       done,
    output logic       drop_activated
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_rad;     // radicand, consumed two bits per iteration from the top
    logic [17:0] r_rem;     // remainder; wide enough that bit 17 flags a negative trial
    logic [7:0]  r_root;
    logic [2:0]  r_cnt;
    logic [7:0]  r_tlim;
    logic        r_done;
    logic        r_drop;

    logic [17:0] w_rem_sh;
    logic [17:0] w_trial;
    logic        w_fit;
    logic [17:0] w_rem_nxt;
    logic [7:0]  w_root_nxt;
    logic        w_load;
    logic        w_last;
    logic        w_drop_hit;

    // One restoring square-root step.
    always_comb begin
        w_rem_sh   = {r_rem[15:0], r_rad[15:14]};
        w_trial    = w_rem_sh - {8'd0, r_root, 2'b01};
        w_fit      = ~w_trial[17];
        w_rem_nxt  = w_fit ? w_trial : w_rem_sh;
        w_root_nxt = {r_root[6:0], w_fit};
        w_drop_hit = drop_en && (t_act >= r_tlim);
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rad   <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_tlim  <= '0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_load) begin
                // height*64 gives the Q4.4 scaling of sqrt(height/4) directly
                r_rad  <= {2'b00, height, 6'b0};
                r_rem  <= '0;
                r_root <= '0;
                r_cnt  <= '0;
                r_drop <= 1'b0;
            end else if (r_state == CALC) begin
                r_rad  <= {r_rad[13:0], 2'b00};
                r_rem  <= w_rem_nxt;
                r_root <= w_root_nxt;
                r_cnt  <= r_cnt + 3'd1;
                if (w_last) begin
                    r_tlim <= w_root_nxt;
                    r_done <= 1'b1;
                end
            end else if ((r_state == DONE) && w_drop_hit) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign t_lim          = r_tlim;
    assign done           = r_done;
    assign drop_activated = r_drop;

endmodule

// File: tb/tb_drop_timer.sv
// Scoreboard bench for drop_timer: each accepted start pushes the expected
// t_lim and done cycle; a negedge monitor pops and compares on every done.
module tb_drop_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] height = '0;
    logic       start = 1'b0;
    logic [7:0] t_act = '0;
    logic       drop_en = 1'b0;
    logic [7:0] t_lim;
    logic       busy;
    logic       done;
    logic       drop_activated;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int exp_tlim_q[$];
    int exp_cyc_q[$];

    drop_timer dut (
        .clk            (clk),
        .rst            (rst),
        .height         (height),
        .start          (start),
        .t_act          (t_act),
        .drop_en        (drop_en),
        .t_lim          (t_lim),
        .busy           (busy),
        .done           (done),
        .drop_activated (drop_activated)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: largest v with v*v <= height*64, found by linear search.
    function automatic int ref_tlim(input int h);
        int v;
        v = 0;
        while ((v + 1) * (v + 1) <= h * 64) v++;
        return v;
    endfunction

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (done) begin
            chk("sb_nonempty", int'(exp_tlim_q.size() != 0), 1);
            if (exp_tlim_q.size() != 0) begin
                chk("t_lim", int'(t_lim), exp_tlim_q.pop_front());
                chk("done_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // Issue an accepted start: pulse one cycle, then scramble height.
    task automatic go(input logic [7:0] h);
        @(negedge clk);
        start  = 1'b1;
        height = h;
        exp_tlim_q.push_back(ref_tlim(int'(h)));
        exp_cyc_q.push_back(cyc + 9);
        @(negedge clk);
        start  = 1'b0;
        height = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        idle(3);
        chk("rst_tlim", int'(t_lim), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_drop", int'(drop_activated), 0);
        rst = 1'b0;
        idle(1);

        // height=100: busy exactly cycles 1..8, done at 9 (checked by monitor)
        go(8'd100);
        for (int i = 1; i <= 9; i++) begin
            chk("busy_win", int'(busy), (i <= 8) ? 1 : 0);
            if (i < 9) @(negedge clk);
        end
        chk("drop_off_en0", int'(drop_activated), 0);

        // Drop threshold, inclusive compare, stickiness
        drop_en = 1'b1;
        t_act   = 8'h4F;
        idle(2);
        chk("drop_below", int'(drop_activated), 0);
        t_act = 8'h50;
        idle(1);
        chk("drop_equal", int'(drop_activated), 1);
        drop_en = 1'b0;
        t_act   = 8'h00;
        idle(2);
        chk("drop_sticky", int'(drop_activated), 1);

        // Restart from DONE with drop set: clears on start edge, t_lim held
        drop_en = 1'b1;
        t_act   = 8'hFF;
        go(8'd255);
        chk("restart_drop_clr", int'(drop_activated), 0);
        chk("restart_busy", int'(busy), 1);
        for (int i = 2; i <= 8; i++) begin
            chk("calc_tlim_hold", int'(t_lim), 8'h50);
            chk("calc_no_drop", int'(drop_activated), 0);
            idle(1);
        end
        idle(2);
        chk("drop_after_255", int'(drop_activated), 1);
        drop_en = 1'b0;
        t_act   = 8'h00;

        // Boundary heights
        go(8'd0);   idle(9);
        go(8'd1);   idle(9);
        go(8'd50);  idle(9);
        go(8'd200); idle(9);

        // start during CALC is ignored
        go(8'd100);
        idle(2);
        start  = 1'b1;
        height = 8'd0;
        idle(1);
        start  = 1'b0;
        idle(12);

        // Reset at cycle 5 of CALC aborts
        go(8'd255);
        idle(3);
        rst = 1'b1;
        exp_tlim_q.delete();
        exp_cyc_q.delete();
        idle(1);
        chk("abort_tlim", int'(t_lim), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_drop", int'(drop_activated), 0);
        // rst wins over a simultaneous start
        start  = 1'b1;
        height = 8'd100;
        idle(1);
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        go(8'd50);
        idle(10);

        chk("sb_drain", exp_tlim_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
